// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory read-port arbiter: default widths, issue-source
// encoding and the saturating drop-counter helper.
package mem_port_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DM   = 2'd1,
    SEL_PF   = 2'd2
  } sel_e;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arb_pf_fifo.sv
// Prefetch request FIFO: synchronous, power-of-two depth, full/empty from an extra
// pointer bit. Storage is not reset; only the pointers are.
module mem_port_arb_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wptr_q, wptr_d;
  logic [PW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{PW{1'b0}}, do_push};
    rptr_d = rptr_q + {{PW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mem_port_arb.sv
// Owner of the shared memory read port: demand misses first, buffered prefetches second,
// in-flight tracker bounds outstanding reads. Define MEM_ARB_DEDUP_EN to suppress duplicates.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int PF_DEPTH = 4,
  parameter int MAX_OUT  = 4,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dm_valid,
  input  logic [ADDR_W-1:0]     dm_addr,
  output logic                  dm_ready,
  input  logic                  pf_valid,
  input  logic [ADDR_W-1:0]     pf_addr,
  output logic                  pf_full,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_addr_out,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] pf_drop_cnt
);

  localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [MAX_OUT-1:0]    trk_vld_q, trk_vld_d;
  logic [ADDR_W-1:0]     trk_addr_q [MAX_OUT];
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]     mem_raddr_q, mem_raddr_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  fifo_full, fifo_empty;
  logic [ADDR_W-1:0]     fifo_head;
  logic                  fifo_push, fifo_pop;

  logic                  dm_hit, hd_hit, pf_hit, rsp_hit;
  logic [IW-1:0]         rsp_idx, alloc_idx;
  logic                  has_free;
  logic                  dm_ready_c;
  logic                  pf_dup;
  logic                  drop_inc;
  sel_e                  sel;
  logic [ADDR_W-1:0]     issue_addr;

  mem_port_arb_pf_fifo #(
    .DEPTH (PF_DEPTH),
    .W     (ADDR_W)
  ) u_pf_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (pf_addr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign has_free = ~&trk_vld_q;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    dm_hit    = 1'b0;
    hd_hit    = 1'b0;
    pf_hit    = 1'b0;
    rsp_hit   = 1'b0;
    rsp_idx   = '0;
    alloc_idx = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!trk_vld_q[i]) alloc_idx = IW'(i);
      if (trk_vld_q[i] && (trk_addr_q[i] == mem_addr_out)) begin
        rsp_hit = 1'b1;
        rsp_idx = IW'(i);
      end
`ifdef MEM_ARB_DEDUP_EN
      if (trk_vld_q[i] && (trk_addr_q[i] == dm_addr))   dm_hit = 1'b1;
      if (trk_vld_q[i] && (trk_addr_q[i] == fifo_head)) hd_hit = 1'b1;
      if (trk_vld_q[i] && (trk_addr_q[i] == pf_addr))   pf_hit = 1'b1;
`endif
    end
  end

  always_comb begin
    sel        = SEL_NONE;
    issue_addr = dm_addr;
    dm_ready_c = 1'b0;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;
    drop_inc   = 1'b0;
    pf_dup     = 1'b0;

    if (dm_valid) begin
      if (dm_hit) begin
        dm_ready_c = 1'b1;
      end else if (has_free) begin
        dm_ready_c = 1'b1;
        sel        = SEL_DM;
      end
    end else if (!fifo_empty) begin
      if (hd_hit) begin
        fifo_pop = 1'b1;
      end else if (has_free) begin
        fifo_pop   = 1'b1;
        sel        = SEL_PF;
        issue_addr = fifo_head;
      end
    end

`ifdef MEM_ARB_DEDUP_EN
    pf_dup = pf_hit || (dm_ready_c && (pf_addr == dm_addr));
`endif
    // A full FIFO drops the incoming prefetch even if the head pops this cycle.
    if (pf_valid && !pf_dup) begin
      if (fifo_full) drop_inc  = 1'b1;
      else           fifo_push = 1'b1;
    end
  end

  // Free uses the response match, alloc uses a slot that was free before the edge.
  always_comb begin
    trk_vld_d = trk_vld_q;
    if (mem_ready && rsp_hit) trk_vld_d[rsp_idx] = 1'b0;
    if (sel != SEL_NONE) trk_vld_d[alloc_idx] = 1'b1;
    mem_re_d    = (sel != SEL_NONE);
    mem_raddr_d = (sel != SEL_NONE) ? issue_addr : mem_raddr_q;
    drop_cnt_d  = drop_inc ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_vld_q   <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      trk_vld_q   <= trk_vld_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sel != SEL_NONE) trk_addr_q[alloc_idx] <= issue_addr;
  end

  assign dm_ready    = dm_ready_c && !rst;
  assign pf_full     = fifo_full;
  assign mem_re      = mem_re_q;
  assign mem_raddr   = mem_raddr_q;
  assign busy        = (|trk_vld_q) || !fifo_empty;
  assign pf_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus random traffic against a queue-based
// reference model of the arbitration rules.
module tb_mem_port_arb;

  localparam int PF_DEPTH = 4;
  localparam int MAX_OUT  = 4;
  localparam int ADDR_W   = 16;
`ifdef MEM_ARB_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dm_valid = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic              dm_ready;
  logic              pf_valid = 1'b0;
  logic [ADDR_W-1:0] pf_addr = '0;
  logic              pf_full;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr_out = '0;
  logic              busy;
  logic [15:0]       pf_drop_cnt;

  always #5 clk = ~clk;

  mem_port_arb #(
    .PF_DEPTH (PF_DEPTH),
    .MAX_OUT  (MAX_OUT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dm_valid     (dm_valid),
    .dm_addr      (dm_addr),
    .dm_ready     (dm_ready),
    .pf_valid     (pf_valid),
    .pf_addr      (pf_addr),
    .pf_full      (pf_full),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .mem_ready    (mem_ready),
    .mem_addr_out (mem_addr_out),
    .busy         (busy),
    .pf_drop_cnt  (pf_drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: in-flight reads as a multiset, prefetch FIFO as a queue.
  logic [15:0] m_inf[$];
  logic [15:0] m_pfq[$];
  logic [15:0] m_drop = '0;
  logic        m_re = 1'b0;
  logic [15:0] m_raddr = '0;

  logic        e_rdy, e_issue, e_pop, e_push, e_drop;
  logic [15:0] e_ia;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_has(input logic [15:0] a);
    foreach (m_inf[k]) if (m_inf[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_inf.delete();
    m_pfq.delete();
    m_drop  = '0;
    m_re    = 1'b0;
    m_raddr = '0;
  endtask

  task automatic model_eval();
    bit pf_silent;
    e_rdy = 0; e_issue = 0; e_pop = 0; e_push = 0; e_drop = 0; e_ia = '0;
    if (dm_valid) begin
      if (DEDUP && m_has(dm_addr)) e_rdy = 1;
      else if (m_inf.size() < MAX_OUT) begin e_rdy = 1; e_issue = 1; e_ia = dm_addr; end
    end else if (m_pfq.size() > 0) begin
      if (DEDUP && m_has(m_pfq[0])) e_pop = 1;
      else if (m_inf.size() < MAX_OUT) begin e_pop = 1; e_issue = 1; e_ia = m_pfq[0]; end
    end
    if (pf_valid) begin
      pf_silent = DEDUP && (m_has(pf_addr) || (e_rdy && pf_addr == dm_addr));
      if (!pf_silent) begin
        if (m_pfq.size() == PF_DEPTH) e_drop = 1;
        else e_push = 1;
      end
    end
  endtask

  task automatic model_commit();
    if (mem_ready) begin
      for (int k = 0; k < m_inf.size(); k++)
        if (m_inf[k] == mem_addr_out) begin m_inf.delete(k); break; end
    end
    if (e_issue) m_inf.push_back(e_ia);
    if (e_pop) void'(m_pfq.pop_front());
    if (e_push) m_pfq.push_back(pf_addr);
    if (e_drop && m_drop != 16'hFFFF) m_drop++;
    m_re = e_issue;
    if (e_issue) m_raddr = e_ia;
  endtask

  // One clock: inputs are already driven; check comb handshake, then registered outputs.
  task automatic tick();
    @(negedge clk);
    model_eval();
    chk("dm_ready", 32'(dm_ready), 32'(e_rdy));
    model_commit();
    @(posedge clk);
    #1;
    chk("mem_re", 32'(mem_re), 32'(m_re));
    if (m_re) chk("mem_raddr", 32'(mem_raddr), 32'(m_raddr));
    chk("pf_full", 32'(pf_full), 32'(m_pfq.size() == PF_DEPTH));
    chk("busy", 32'(busy), 32'((m_inf.size() > 0) || (m_pfq.size() > 0)));
    chk("pf_drop_cnt", 32'(pf_drop_cnt), 32'(m_drop));
    if (e_rdy) dm_valid = 1'b0;
    pf_valid  = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic demand(input logic [15:0] a);
    dm_valid = 1'b1;
    dm_addr  = a;
    tick();
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && (m_inf.size() > 0 || m_pfq.size() > 0 || dm_valid); g++) begin
      if (m_inf.size() > 0) begin mem_ready = 1'b1; mem_addr_out = m_inf[0]; end
      tick();
    end
    chk("drained_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    // Reset state, with a demand pending to show dm_ready is gated.
    dm_valid = 1'b1;
    dm_addr  = 16'h0040;
    #2;
    chk("rst_dm_ready", 32'(dm_ready), 32'(0));
    chk("rst_mem_re", 32'(mem_re), 32'(0));
    chk("rst_mem_raddr", 32'(mem_raddr), 32'(0));
    chk("rst_pf_full", 32'(pf_full), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_drop", 32'(pf_drop_cnt), 32'(0));
    dm_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single demand on an idle port: one-cycle read strobe the next cycle.
    demand(16'h0040);
    tick();
    drain();

    // Demand and prefetch together: demand first, prefetch the cycle after.
    dm_valid = 1'b1; dm_addr = 16'h0010;
    pf_valid = 1'b1; pf_addr = 16'h0020;
    tick();
    tick();
    tick();
    drain();

    // Fifth demand held until a response frees a tracker slot.
    for (int k = 0; k < 4; k++) demand(16'h0010 + 16'(k));
    demand(16'h0050);
    tick();
    mem_ready = 1'b1; mem_addr_out = 16'h0010;
    tick();
    tick();
    drain();

    // Prefetch burst into a full tracker: four buffered, two counted drops.
    for (int k = 0; k < 4; k++) demand(16'h0030 + 16'(k));
    for (int k = 0; k < 6; k++) begin
      pf_valid = 1'b1; pf_addr = 16'h0100 + 16'(k);
      tick();
    end
    chk("burst_pf_full", 32'(pf_full), 32'(1));
    chk("burst_drop", 32'(pf_drop_cnt), 32'(2));
    drain();

    // Demand to an address already being prefetched.
    pf_valid = 1'b1; pf_addr = 16'h0200;
    tick();
    tick();
    demand(16'h0200);
    tick();
    drain();

    // Reset with three reads in flight; a late response must be ignored.
    for (int k = 0; k < 3; k++) demand(16'h0060 + 16'(k));
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_re", 32'(mem_re), 32'(0));
    chk("mid_rst_raddr", 32'(mem_raddr), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_drop", 32'(pf_drop_cnt), 32'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1'b1; mem_addr_out = 16'h0060;
    tick();
    chk("late_rsp_busy", 32'(busy), 32'(0));

    // Random traffic over a small address pool to provoke duplicates and back-pressure.
    for (int c = 0; c < 400; c++) begin
      if (!dm_valid && $urandom_range(0, 2) == 0) begin
        dm_valid = 1'b1;
        dm_addr  = 16'h0200 + 16'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 2) == 0) begin
        pf_valid = 1'b1;
        pf_addr  = 16'h0200 + 16'($urandom_range(0, 7));
      end
      if (m_inf.size() > 0 && $urandom_range(0, 1) == 0) begin
        mem_ready    = 1'b1;
        mem_addr_out = m_inf[$urandom_range(0, m_inf.size() - 1)];
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ready    = 1'b1;
        mem_addr_out = 16'hFFF0;
      end
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
